// File: rtl/lector_ad_dia_2dig.sv
// One read cycle on the RTC multiplexed AD bus to fetch the day register,
// then BCD validation and conversion to a 0..30 day index.
module lector_ad_dia_2dig #(
    parameter logic [7:0] ADDR_DIA = 8'h24,
    parameter int         T_FASE   = 10
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       iniciar,
    input  logic [7:0] dato_in,
    output logic [7:0] dato_out,
    output logic       oe_bus,
    output logic       cs_n,
    output logic       ad_n,
    output logic       rd_n,
    output logic [7:0] datos_Dia,
    output logic [4:0] q_dia,
    output logic       ocupado,
    output logic       listo,
    output logic       error
);

    localparam int CW = $clog2(T_FASE);
    localparam logic [CW-1:0] ULTIMO = CW'(T_FASE - 1);

    localparam logic [2:0] REPOSO = 3'd0;
    localparam logic [2:0] DIR    = 3'd1;
    localparam logic [2:0] ESPERA = 3'd2;
    localparam logic [2:0] LEER   = 3'd3;
    localparam logic [2:0] FIN    = 3'd4;

    logic [2:0]    state;
    logic [2:0]    state_n;
    logic [CW-1:0] cnt;
    logic [7:0]    captura;
    logic          fin_fase;
    logic [3:0]    decenas;
    logic [3:0]    unidades;
    logic [6:0]    suma;
    logic [4:0]    q_conv;
    logic          valido;

    assign fin_fase = (cnt == ULTIMO);

    always_comb begin
        state_n = state;
        case (state)
            REPOSO:  if (iniciar)  state_n = DIR;
            DIR:     if (fin_fase) state_n = ESPERA;
            ESPERA:  if (fin_fase) state_n = LEER;
            LEER:    if (fin_fase) state_n = FIN;
            FIN:     if (fin_fase) state_n = REPOSO;
            default: state_n = REPOSO;
        endcase
    end

    // Tens must be 0..3, units 0..9, and the day 01..31.
    always_comb begin
        decenas  = captura[7:4];
        unidades = captura[3:0];
        valido   = (decenas <= 4'd3) && (unidades <= 4'd9) &&
                   (captura != 8'h00) && (captura <= 8'h31);
        suma     = {3'b000, decenas} * 7'd10 + {3'b000, unidades};
        q_conv   = 5'(suma - 7'd1);
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= REPOSO;
            cnt     <= '0;
            captura <= 8'h00;
        end else begin
            state <= state_n;
            if (state == REPOSO || fin_fase) cnt <= '0;
            else                             cnt <= cnt + 1'b1;
            if (state == LEER && fin_fase) captura <= dato_in;
        end
    end

    // Bus outputs are registered from the next state so they line up with the FSM.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dato_out  <= 8'h00;
            oe_bus    <= 1'b0;
            cs_n      <= 1'b1;
            ad_n      <= 1'b1;
            rd_n      <= 1'b1;
            ocupado   <= 1'b0;
            listo     <= 1'b0;
            error     <= 1'b0;
            datos_Dia <= 8'h01;
            q_dia     <= 5'd0;
        end else begin
            dato_out <= (state_n == DIR) ? ADDR_DIA : 8'h00;
            oe_bus   <= (state_n == DIR);
            cs_n     <= (state_n == REPOSO);
            ad_n     <= (state_n != DIR);
            rd_n     <= (state_n != LEER);
            ocupado  <= (state_n != REPOSO);
            listo    <= (state == FIN) && fin_fase && valido;
            error    <= (state == FIN) && fin_fase && !valido;
            if (state == FIN && fin_fase && valido) begin
                datos_Dia <= captura;
                q_dia     <= q_conv;
            end
        end
    end

endmodule

// File: tb/tb_lector_ad_dia_2dig.sv
// Self-checking bench: RTC bus model, decimal reference model for the day value.
module tb_lector_ad_dia_2dig;

    localparam int         T    = 10;
    localparam logic [7:0] ADDR = 8'h24;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       iniciar = 1'b0;
    logic [7:0] dato_in;
    logic [7:0] dato_out;
    logic       oe_bus, cs_n, ad_n, rd_n;
    logic [7:0] datos_Dia;
    logic [4:0] q_dia;
    logic       ocupado, listo, error;

    logic [7:0] rtc_val = 8'h00;

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_bcd = 8'h01;
    logic [4:0] exp_q   = 5'd0;

    lector_ad_dia_2dig #(.ADDR_DIA(ADDR), .T_FASE(T)) dut (
        .clk(clk), .reset(reset), .iniciar(iniciar), .dato_in(dato_in),
        .dato_out(dato_out), .oe_bus(oe_bus), .cs_n(cs_n), .ad_n(ad_n),
        .rd_n(rd_n), .datos_Dia(datos_Dia), .q_dia(q_dia),
        .ocupado(ocupado), .listo(listo), .error(error)
    );

    always #5 clk = ~clk;

    // RTC answers only while the read strobe is low; junk otherwise.
    always_comb dato_in = (!rd_n) ? rtc_val : 8'hEE;

    always @(negedge clk) begin
        if (reset === 1'b1) begin
            checks++;
            if ((!rd_n && oe_bus) || (!ad_n && !rd_n) || (ocupado && cs_n) || (!ocupado && !cs_n)) begin
                errors++;
                $display("[TB] FAIL protocol: rd_n=%b oe_bus=%b ad_n=%b cs_n=%b ocupado=%b",
                         rd_n, oe_bus, ad_n, cs_n, ocupado);
            end
        end
    end

    // Reference model: a day is valid if both nibbles are decimal digits and 1..31.
    function automatic bit ref_valid(input logic [7:0] b);
        int t, u, d;
        t = int'(b[7:4]);
        u = int'(b[3:0]);
        d = t * 10 + u;
        return (t < 10) && (u < 10) && (d >= 1) && (d <= 31);
    endfunction

    function automatic logic [4:0] ref_index(input logic [7:0] b);
        int d;
        d = int'(b[7:4]) * 10 + int'(b[3:0]);
        return 5'(d - 1);
    endfunction

    task automatic model_update(input logic [7:0] b);
        if (ref_valid(b)) begin
            exp_bcd = b;
            exp_q   = ref_index(b);
        end
    endtask

    task automatic run_read(input logic [7:0] val, input int busy_at,
                            output int event_at, output int n_listo, output int n_err,
                            output int ad_low, output int rd_low, output bit win_ok);
        rtc_val  = val;
        event_at = -1;
        n_listo  = 0;
        n_err    = 0;
        ad_low   = 0;
        rd_low   = 0;
        win_ok   = 1'b1;
        @(negedge clk);
        iniciar = 1'b1;
        @(posedge clk);
        for (int m = 0; m < 4 * T + 4; m++) begin
            @(negedge clk);
            iniciar = (m == busy_at);
            if (listo || error) begin
                if (event_at < 0) event_at = m;
                if (listo) n_listo++;
                if (error) n_err++;
            end
            if (!ad_n) begin
                ad_low++;
                if (dato_out !== ADDR || oe_bus !== 1'b1 || m >= T) win_ok = 1'b0;
            end
            if (!rd_n) begin
                rd_low++;
                if (m < 2 * T || m >= 3 * T) win_ok = 1'b0;
            end
        end
        iniciar = 1'b0;
    endtask

    task automatic check_read(input string name, input logic [7:0] val, input int busy_at);
        int ev, nl, ne, al, rl;
        bit wok;
        bit ok;
        run_read(val, busy_at, ev, nl, ne, al, rl, wok);
        ok = ref_valid(val);
        model_update(val);
        checks++;
        if (ev !== 4 * T) begin
            errors++;
            $display("[TB] FAIL %s event_cycle: got %0d expected %0d", name, ev, 4 * T);
        end
        checks++;
        if (nl !== (ok ? 1 : 0) || ne !== (ok ? 0 : 1)) begin
            errors++;
            $display("[TB] FAIL %s pulses val=%h: listo=%0d error=%0d expected listo=%0d error=%0d",
                     name, val, nl, ne, ok ? 1 : 0, ok ? 0 : 1);
        end
        checks++;
        if (al !== T || rl !== T || !wok) begin
            errors++;
            $display("[TB] FAIL %s strobes: ad_low=%0d rd_low=%0d window_ok=%0b expected %0d %0d 1",
                     name, al, rl, wok, T, T);
        end
        checks++;
        if (datos_Dia !== exp_bcd || q_dia !== exp_q) begin
            errors++;
            $display("[TB] FAIL %s data val=%h: datos_Dia=%h q_dia=%0d expected %h %0d",
                     name, val, datos_Dia, q_dia, exp_bcd, exp_q);
        end
    endtask

    task automatic test_reset;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({cs_n, ad_n, rd_n, oe_bus, ocupado, listo, error} !== 7'b1110000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl: cs_n/ad_n/rd_n/oe/ocupado/listo/error=%b expected 1110000",
                     {cs_n, ad_n, rd_n, oe_bus, ocupado, listo, error});
        end
        checks++;
        if (dato_out !== 8'h00 || datos_Dia !== 8'h01 || q_dia !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_data: dato_out=%h datos_Dia=%h q_dia=%0d expected 00 01 0",
                     dato_out, datos_Dia, q_dia);
        end
        reset = 1'b1;
        exp_bcd = 8'h01;
        exp_q   = 5'd0;
        @(negedge clk);
    endtask

    task automatic test_basic_read;
        check_read("basic_15", 8'h15, -1);
        checks++;
        if (q_dia !== 5'd14) begin
            errors++;
            $display("[TB] FAIL basic_q: got %0d expected 14", q_dia);
        end
    endtask

    task automatic test_boundaries;
        check_read("bound_31", 8'h31, -1);
        checks++;
        if (q_dia !== 5'd30) begin
            errors++;
            $display("[TB] FAIL bound_31_q: got %0d expected 30", q_dia);
        end
        check_read("bound_01", 8'h01, -1);
        checks++;
        if (q_dia !== 5'd0) begin
            errors++;
            $display("[TB] FAIL bound_01_q: got %0d expected 0", q_dia);
        end
    endtask

    task automatic test_invalid;
        logic [7:0] bad [3] = '{8'h00, 8'h32, 8'h1A};
        check_read("inv_pre_09", 8'h09, -1);
        foreach (bad[i]) check_read("invalid", bad[i], -1);
        checks++;
        if (datos_Dia !== 8'h09 || q_dia !== 5'd8) begin
            errors++;
            $display("[TB] FAIL invalid_hold: datos_Dia=%h q_dia=%0d expected 09 8", datos_Dia, q_dia);
        end
    endtask

    task automatic test_busy;
        check_read("busy", 8'h27, 2 * T + 3);
    endtask

    task automatic test_random;
        logic [7:0] v;
        for (int i = 0; i < 16; i++) begin
            if (i % 2 == 0) v = 8'($urandom_range(0, 255));
            else            v = {4'($urandom_range(0, 3)), 4'($urandom_range(0, 9))};
            check_read("random", v, -1);
        end
    endtask

    task automatic test_reset_mid;
        int waited;
        bit seen_listo;
        rtc_val = 8'h30;
        @(negedge clk);
        iniciar = 1'b1;
        @(negedge clk);
        iniciar = 1'b0;
        waited = 0;
        while (rd_n !== 1'b0 && waited < 5 * T) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (rd_n !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_reach_leer: rd_n=%b expected 0", rd_n);
        end
        repeat (3) @(negedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if (rd_n !== 1'b1 || cs_n !== 1'b1 || oe_bus !== 1'b0 || ocupado !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_mid_async: rd_n=%b cs_n=%b oe_bus=%b ocupado=%b expected 1 1 0 0",
                     rd_n, cs_n, oe_bus, ocupado);
        end
        exp_bcd = 8'h01;
        exp_q   = 5'd0;
        seen_listo = 1'b0;
        repeat (3) begin
            @(negedge clk);
            if (listo || error) seen_listo = 1'b1;
        end
        reset = 1'b1;
        repeat (4 * T + 2) begin
            @(negedge clk);
            if (listo || error) seen_listo = 1'b1;
        end
        checks++;
        if (seen_listo !== 1'b0 || datos_Dia !== 8'h01 || q_dia !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_mid_no_done: pulse=%b datos_Dia=%h q_dia=%0d expected 0 01 0",
                     seen_listo, datos_Dia, q_dia);
        end
        check_read("after_reset_22", 8'h22, -1);
        checks++;
        if (q_dia !== 5'd21) begin
            errors++;
            $display("[TB] FAIL after_reset_q: got %0d expected 21", q_dia);
        end
    endtask

    initial begin
        test_reset();
        test_basic_read();
        test_boundaries();
        test_invalid();
        test_busy();
        test_random();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/lector_ad_dia_2dig.md
# lector_ad_dia_2dig

Read-side companion of the day-setting counter. It runs one read cycle on the RTC's multiplexed address/data bus to fetch the day register. It validates the returned two-digit BCD value, converts it to the counter's 0..30 day index, and presents both forms to the display/reload logic. It sits between the RTC bus pins and the day counter, and is triggered by the periodic refresh controller.

## Interface
- ADDR_DIA, 8'h24: RTC day-register address driven in the address phase
- T_FASE, 10: length of each bus phase in clk cycles (≥2)
- clk  in  1  system clock (100 MHz)
- reset  in  1  asynchronous, active-low reset
- iniciar  in  1  read request; sampled only in REPOSO
- dato_in  in  8  AD bus value returned by the RTC (tristate resolved at top level)
- dato_out  out  8  value driven onto AD bus
- oe_bus  out  1  high = block drives dato_out onto the bus
- cs_n  out  1  RTC chip select, active low
- ad_n  out  1  address strobe, active low
- rd_n  out  1  read strobe, active low
- datos_Dia  out  8  last valid day as BCD {tens, units}
- q_dia  out  5  last valid day as index, day-1 (0..30)
- ocupado  out  1  high while FSM not in REPOSO
- listo  out  1  one-cycle pulse: read done, data valid and loaded
- error  out  1  one-cycle pulse: read done, data rejected

## Operation
- FSM states: REPOSO → DIR → ESPERA → LEER → FIN → REPOSO. A phase counter holds each non-idle state for exactly T_FASE cycles.
- REPOSO: cs_n=ad_n=rd_n=1, oe_bus=0. If iniciar=1, go to DIR.
- DIR: cs_n=0, ad_n=0, oe_bus=1, dato_out=ADDR_DIA.
- ESPERA: cs_n=0, ad_n=1, oe_bus=0, dato_out=0 (bus released before read).
- LEER: cs_n=0, rd_n=0, oe_bus=0. dato_in is captured into an internal register on the clock edge that ends the last LEER cycle.
- FIN: cs_n=0, rd_n=1. The captured byte is validated and converted here (combinational from the capture register).
- Validation: tens = byte[7:4] ≤ 3, units = byte[3:0] ≤ 9, and the value is in 01..31 (reject 00, 32..39).
- Conversion: q_dia = 10·tens + units − 1, 5-bit, computed with widened intermediate (no truncation before subtract).
- On FIN → REPOSO:
  - Valid byte: datos_Dia ← byte, q_dia ← converted value, listo=1.
  - Invalid byte: outputs hold, error=1.
- iniciar while ocupado=1 is ignored (not queued).
- Reset (reset=0) at any time: all outputs go to reset values immediately, FSM to REPOSO, phase counter and capture register cleared. Strobes return high asynchronously.
- Reset values: cs_n=1, ad_n=1, rd_n=1, oe_bus=0, dato_out=0, datos_Dia=8'h01, q_dia=0, ocupado=0, listo=0, error=0.

## Timing
- iniciar high at edge k (in REPOSO) → DIR occupies cycles k+1 .. k+T_FASE.
- ESPERA, LEER and FIN follow, each T_FASE cycles.
- listo/error high for the single cycle k+1+4·T_FASE. datos_Dia/q_dia change on that same edge.
- Earliest next accepted iniciar: sampled at the edge ending the listo/error cycle.
- All outputs registered; no combinational path from dato_in or iniciar to outputs.
- oe_bus is never high while rd_n=0; ad_n and rd_n are never low simultaneously.
- Boundaries:
  - 8'h31 → q_dia=30.
  - 8'h01 → q_dia=0.
  - 8'h00, 8'h32, 8'h1A → error.

## Test plan
- Reset, T_FASE=10: hold reset=0 → all outputs at reset values. Release, iniciar pulse at edge k, RTC returns 8'h15 → dato_out=8'h24 with ad_n=0 for 10 cycles; listo at cycle k+41; datos_Dia=8'h15, q_dia=14.
- Boundaries: reads of 8'h31 then 8'h01 → q_dia=30 then 0, listo each time, no error.
- Invalid data: read 8'h00, 8'h32, 8'h1A after a valid 8'h09 → error pulse each time; datos_Dia stays 8'h09, q_dia stays 8.
- Busy: iniciar re-asserted during LEER → ignored; exactly one listo, and the strobe sequence is not restarted.
- Reset mid-operation: reset=0 during LEER → rd_n=1, cs_n=1, oe_bus=0 immediately; no listo. After release, a new read of 8'h22 → q_dia=21.
- Bus protocol checker across all runs: oe_bus=0 whenever rd_n=0; ad_n and rd_n never both low; cs_n=0 throughout DIR..FIN.
